gshare_update_ctrl: RTL and testbench
=====================================

// Module: gshare_update_ctrl
// PURPOSE
// Predict/update controller driving pattern_state_table as a gshare predictor.
// - Forms the read index from the fetch PC XOR a speculative global history register (GHR).
// - Queues in-flight predictions and, on in-order branch resolution, runs a read-modify-write
//   of the 2-bit counter.
// - Raises mispredict and restores history on a wrong prediction.
// PARAMETERS
// DW   4   PHT index width; matches pattern_state_table DW
// QD   4   in-flight prediction queue depth; power of 2, >=2
// PCW  32  fetch PC width
// PORTS
// clk            in   1    clock; all flops rising edge
// reset_n        in   1    asynchronous, active-low reset
// pred_valid     in   1    a branch is being predicted this cycle
// pred_pc        in   PCW  PC of that branch
// pred_ready     out  1    prediction accepted when pred_valid & pred_ready
// Raddr          out  DW   PHT read index = pred_pc[DW+1:2] ^ ghr (combinational)
// state_for_pred in   2    PHT counter at Raddr
// pred_taken     out  1    = state_for_pred[1]
// res_valid      in   1    oldest queued branch resolved
// res_taken      in   1    actual outcome
// res_ready      out  1    resolution accepted when res_valid & res_ready
// Waddr          out  DW   PHT update index (registered)
// current_state  in   2    PHT registered read of Waddr
// next_state     out  2    counter value to write
// en_taken       out  1    PHT write enable
// mispredict     out  1    1-cycle pulse: resolved outcome != queued prediction
// stat_branches  out  16   resolved-branch count (see CONFIGURATION)
// stat_mispred   out  16   mispredict count (see CONFIGURATION)
// BEHAVIOUR
// - Reset values:
//   - ghr=0, queue empty, FSM=IDLE, Waddr=0.
//   - en_taken=0, next_state=0, mispredict=0; stats=0.
//   - Reset asserted mid-update abandons the update; no en_taken is issued.
// - Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
//   - Taken: saturating +1 (11 stays 11). Not taken: saturating -1 (00 stays 00).
// - Predict:
//   - pred_ready = ~full & ~flush.
//   - On accept, push {Raddr, pred_taken, ghr} and set ghr <= {ghr[DW-2:0], pred_taken}.
// - Update FSM:
//   - IDLE: res_ready = ~empty. On accept, Waddr <= head.idx, latch res_taken -> READ.
//   - READ: PHT samples memory[Waddr] at this cycle's closing edge -> WRITE.
//   - WRITE:
//     - en_taken=1, next_state=sat(current_state, taken); PHT writes at negedge.
//     - Pop head -> IDLE.
//   - res_ready=0 in READ/WRITE; one resolution per 3 cycles.
// - Mispredict (WRITE & taken != head.pred):
//   - flush=1, mispredict=1.
//   - Queue emptied; ghr <= {head.ghr[DW-2:0], taken}.
//   - pred_ready=0 that cycle, so no push coincides with a flush.
// - Simultaneous push and pop (no mispredict): occupancy unchanged; ghr takes the push update.
// - Queue pointers wrap modulo QD; full/empty use a log2(QD)+1-bit count.
// - res_valid while empty: ignored (res_ready=0).
// CONFIGURATION
// - PRED_STATS_EN defined:
//   - stat_branches +1 on every WRITE; stat_mispred +1 on every mispredict.
//   - Both saturate at 16'hFFFF.
// - Undefined: both stat ports tied to 0 and no counter flops are built.
// TESTING
// - Reset, DW=4, pc=0x24, ghr=0: Raddr=9, pred_ready=1, res_ready=0, en_taken=0.
// - Predict pc=0x24 with state_for_pred=01; resolve taken, current_state=01:
//   - pred_taken=0; en_taken 2 cycles after accept.
//   - next_state=10, Waddr=9, mispredict=1, ghr=0001.
// - Push QD predictions: pred_ready=0 after 4th.
//   - Resolve head correctly: next push accepted the cycle after WRITE.
// - Saturation: current_state=11 + taken -> 11; current_state=00 + not-taken -> 00; mispredict=0.
// - Mispredict with 3 younger queued: queue empty after WRITE, res_ready=0, ghr=restored checkpoint.
// - reset_n low during READ: no en_taken, queue empty.
//   - With PRED_STATS_EN: 5 resolves, 2 wrong -> stat_branches=5, stat_mispred=2.

Source files
------------

// File: rtl/gshare_update_ctrl_if.sv
// Signal bundle between the gshare update controller and its neighbours:
// fetch-side predict handshake, resolve handshake, PHT read/write ports and
// statistics outputs. The controller uses the slave modport.
interface gshare_update_ctrl_if #(
  parameter int DW  = 4,
  parameter int PCW = 32
);
  // predict side
  logic           pred_valid;
  logic [PCW-1:0] pred_pc;
  logic           pred_ready;
  logic           pred_taken;
  // resolve side
  logic           res_valid;
  logic           res_taken;
  logic           res_ready;
  logic           mispredict;
  // pattern_state_table side
  logic [DW-1:0]  Raddr;
  logic [1:0]     state_for_pred;
  logic [DW-1:0]  Waddr;
  logic [1:0]     current_state;
  logic [1:0]     next_state;
  logic           en_taken;
  // statistics
  logic [15:0]    stat_branches;
  logic [15:0]    stat_mispred;

  modport slave (
    input  pred_valid, pred_pc, state_for_pred, res_valid, res_taken, current_state,
    output pred_ready, pred_taken, Raddr, res_ready, Waddr, next_state, en_taken,
           mispredict, stat_branches, stat_mispred
  );

  modport master (
    output pred_valid, pred_pc, state_for_pred, res_valid, res_taken, current_state,
    input  pred_ready, pred_taken, Raddr, res_ready, Waddr, next_state, en_taken,
           mispredict, stat_branches, stat_mispred
  );
endinterface

// File: rtl/gshare_update_ctrl.sv
// gshare predict/update controller for pattern_state_table.
// Predict: index = pc[DW+1:2] ^ speculative GHR; each accepted prediction is
// queued with its index, predicted direction and GHR checkpoint.
// Update: in-order resolutions run IDLE -> READ -> WRITE, a read-modify-write
// of the 2-bit saturating counter. A wrong prediction flushes the queue and
// rebuilds the GHR from the head checkpoint plus the real outcome.
// Optional feature macro: PRED_STATS_EN (resolved / mispredicted counters).
module gshare_update_ctrl #(
  parameter int DW  = 4,
  parameter int QD  = 4,
  parameter int PCW = 32
) (
  input  logic clk,
  input  logic reset_n,
  gshare_update_ctrl_if.slave bus
);

  localparam int AW = $clog2(QD);
  localparam logic [AW:0] QD_CNT = (AW+1)'(QD);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  typedef struct packed {
    logic [DW-1:0] idx;
    logic          pred;
    logic [DW-1:0] ghr;
  } entry_t;

  state_t        state, state_nxt;
  entry_t        q_mem [QD];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] ghr;
  logic [DW-1:0] waddr_q;
  logic          taken_q;
  logic          full, empty, push, pop, flush, res_accept;
  logic          res_ready_c, en_taken_c;
  logic [1:0]    next_state_c;

  // Only pc[DW+1:2] feeds the index; remaining PC bits are intentionally unused.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[PCW-1:DW+2], bus.pred_pc[1:0]};

  function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic tk);
    if (tk) return (cur == 2'b11) ? 2'b11 : cur + 2'b01;
    else    return (cur == 2'b00) ? 2'b00 : cur - 2'b01;
  endfunction

  assign head       = q_mem[rd_ptr];
  assign full       = (count == QD_CNT);
  assign empty      = (count == '0);
  assign push       = bus.pred_valid & bus.pred_ready;
  assign pop        = (state == WRITE);
  assign res_accept = bus.res_valid & res_ready_c;

  assign bus.Raddr      = bus.pred_pc[DW+1:2] ^ ghr;
  assign bus.pred_taken = bus.state_for_pred[1];
  assign bus.pred_ready = ~full & ~flush;
  assign bus.res_ready  = res_ready_c;
  assign bus.Waddr      = waddr_q;
  assign bus.en_taken   = en_taken_c;
  assign bus.next_state = next_state_c;
  assign bus.mispredict = flush;

  // Update FSM: next state and PHT write-side outputs.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_nxt    = state;
    res_ready_c  = 1'b0;
    en_taken_c   = 1'b0;
    next_state_c = 2'b00;
    flush        = 1'b0;
    unique case (state)
      IDLE: begin
        res_ready_c = ~empty;
        if (bus.res_valid && !empty) state_nxt = READ;
      end
      READ:  state_nxt = WRITE;
      WRITE: begin
        en_taken_c   = 1'b1;
        next_state_c = sat_update(bus.current_state, taken_q);
        flush        = (taken_q != head.pred);
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, update index and latched outcome.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state   <= IDLE;
      waddr_q <= '0;
      taken_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (res_accept) begin
        waddr_q <= head.idx;
        taken_q <= bus.res_taken;
      end
    end
  end

  // Queue pointers and occupancy; a flush empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    // NOTE: entries are not reset; count/pointers decide validity, so stale contents are never observed.
    if (push) q_mem[wr_ptr] <= '{idx: bus.Raddr, pred: bus.pred_taken, ghr: ghr};
  end

  // Speculative global history; a mispredict restores the head checkpoint.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ghr <= '0;
    else if (flush) ghr <= {head.ghr[DW-2:0], taken_q};
    else if (push)  ghr <= {ghr[DW-2:0], bus.pred_taken};
  end

`ifdef PRED_STATS_EN
  logic [15:0] stat_br_q, stat_mp_q;

  // Saturating resolved-branch and mispredict counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (pop && stat_br_q != 16'hFFFF)   stat_br_q <= stat_br_q + 16'd1;
      if (flush && stat_mp_q != 16'hFFFF) stat_mp_q <= stat_mp_q + 16'd1;
    end
  end

  assign bus.stat_branches = stat_br_q;
  assign bus.stat_mispred  = stat_mp_q;
`else
  assign bus.stat_branches = 16'd0;
  assign bus.stat_mispred  = 16'd0;
`endif

endmodule

// File: tb/tb_gshare_update_ctrl.sv
// Directed bench for gshare_update_ctrl with a scoreboard: each resolve pushes
// its expected PHT write {Waddr, next_state, mispredict}; a monitor pops and
// compares whenever en_taken is seen.
module tb_gshare_update_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [3:0] waddr;
    logic [1:0] ns;
    logic       mis;
  } exp_t;

  exp_t sb[$];

  gshare_update_ctrl_if #(.DW(4), .PCW(32)) bus ();

  gshare_update_ctrl #(.DW(4), .QD(4), .PCW(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every PHT write must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.en_taken === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("waddr", 32'(bus.Waddr), 32'(e.waddr));
        check("next_state", 32'(bus.next_state), 32'(e.ns));
        check("mispredict", 32'(bus.mispredict), 32'(e.mis));
      end
    end
  end

  task automatic predict(input logic [31:0] pc, input logic [1:0] sfp,
                         input logic [3:0] exp_raddr, input logic exp_pt);
    bit ok = 0;
    @(posedge clk); #1;
    bus.pred_valid = 1'b1;
    bus.pred_pc = pc;
    bus.state_for_pred = sfp;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pred_ready) begin ok = 1; break; end
    end
    if (!ok) check("pred_accept_timeout", 32'd0, 32'd1);
    check("raddr", 32'(bus.Raddr), 32'(exp_raddr));
    check("pred_taken", 32'(bus.pred_taken), 32'(exp_pt));
    @(posedge clk); #1;
    bus.pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic tk, input logic [1:0] cur, input logic [3:0] exp_w,
                         input logic [1:0] exp_ns, input logic exp_mis, input logic exp_pr_write);
    bit ok = 0;
    sb.push_back('{waddr: exp_w, ns: exp_ns, mis: exp_mis});
    @(posedge clk); #1;
    bus.res_valid = 1'b1;
    bus.res_taken = tk;
    bus.current_state = cur;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("res_accept_timeout", 32'd0, 32'd1);
      bus.res_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    @(negedge clk);
    check("en_taken_in_read", 32'(bus.en_taken), 32'd0);
    @(negedge clk);
    check("en_taken_in_write", 32'(bus.en_taken), 32'd1);
    check("pred_ready_in_write", 32'(bus.pred_ready), 32'(exp_pr_write));
  endtask

  initial begin
    reset_n = 1'b0;
    bus.pred_valid = 1'b0;
    bus.pred_pc = 32'h24;
    bus.state_for_pred = 2'b00;
    bus.res_valid = 1'b0;
    bus.res_taken = 1'b0;
    bus.current_state = 2'b00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_raddr", 32'(bus.Raddr), 32'd9);
    check("rst_pred_ready", 32'(bus.pred_ready), 32'd1);
    check("rst_res_ready", 32'(bus.res_ready), 32'd0);
    check("rst_en_taken", 32'(bus.en_taken), 32'd0);
    check("rst_next_state", 32'(bus.next_state), 32'd0);
    check("rst_mispredict", 32'(bus.mispredict), 32'd0);
    check("rst_waddr", 32'(bus.Waddr), 32'd0);
    check("rst_stat_br", 32'(bus.stat_branches), 32'd0);
    check("rst_stat_mp", 32'(bus.stat_mispred), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Predict not-taken at pc 0x24, resolve taken: WNT->WT, mispredict, ghr=0001
    predict(32'h24, 2'b01, 4'd9, 1'b0);
    resolve(1'b1, 2'b01, 4'd9, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    check("ghr_after_mispredict_raddr", 32'(bus.Raddr), 32'd8);
    check("empty_res_ready", 32'(bus.res_ready), 32'd0);

    // Fill the queue (ghr 0001 -> 0011 -> 0111 -> 1110 -> 1100)
    predict(32'h00, 2'b11, 4'd1,  1'b1);
    predict(32'h04, 2'b10, 4'd2,  1'b1);
    predict(32'h08, 2'b00, 4'd5,  1'b0);
    predict(32'h0C, 2'b01, 4'd13, 1'b0);
    @(negedge clk);
    check("full_pred_ready", 32'(bus.pred_ready), 32'd0);
    check("full_res_ready", 32'(bus.res_ready), 32'd1);

    // Correct resolve of head, ST stays ST; slot frees right after WRITE
    resolve(1'b1, 2'b11, 4'd1, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    check("push_after_write", 32'(bus.pred_ready), 32'd1);
    predict(32'h10, 2'b11, 4'd8, 1'b1);             // ghr -> 1001

    resolve(1'b1, 2'b10, 4'd2, 2'b11, 1'b0, 1'b0);
    resolve(1'b0, 2'b00, 4'd5, 2'b00, 1'b0, 1'b1);  // SNT stays SNT

    // Head plus three younger, then mispredict on head
    predict(32'h14, 2'b00, 4'd12, 1'b0);            // ghr -> 0010
    predict(32'h18, 2'b01, 4'd4,  1'b0);            // ghr -> 0100
    resolve(1'b1, 2'b01, 4'd13, 2'b10, 1'b1, 1'b0); // checkpoint 1110 -> ghr 1101
    @(posedge clk); #1;
    bus.pred_pc = 32'h00;
    @(negedge clk);
    check("flush_res_ready", 32'(bus.res_ready), 32'd0);
    check("flush_pred_ready", 32'(bus.pred_ready), 32'd1);
    check("flush_ghr_restore_raddr", 32'(bus.Raddr), 32'd13);

`ifdef PRED_STATS_EN
    check("stat_branches", 32'(bus.stat_branches), 32'd5);
    check("stat_mispred", 32'(bus.stat_mispred), 32'd2);
`else
    check("stat_branches_off", 32'(bus.stat_branches), 32'd0);
    check("stat_mispred_off", 32'(bus.stat_mispred), 32'd0);
`endif

    // Reset asserted while the update is in READ: no write may follow
    predict(32'h00, 2'b10, 4'd13, 1'b1);
    @(posedge clk); #1;
    bus.res_valid = 1'b1;
    bus.res_taken = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.res_ready) begin ok = 1; break; end
      end
      if (!ok) check("rst_test_accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.pred_pc = 32'h24;
    repeat (5) @(negedge clk);
    check("rst_mid_en_taken", 32'(bus.en_taken), 32'd0);
    check("rst_mid_res_ready", 32'(bus.res_ready), 32'd0);
    check("rst_mid_pred_ready", 32'(bus.pred_ready), 32'd1);
    check("rst_mid_raddr", 32'(bus.Raddr), 32'd9);

    // Every expected write must have been observed
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
